// File: rtl/boot_loader.sv
// rtl/boot_loader.sv - byte-stream instruction image loader with length, checksum and core reset hold
module boot_loader #(
  parameter int instructions = 256,
  localparam int AW = $clog2(instructions)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  input  logic          start,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          core_rst_n,
  output logic          done,
  output logic          error
);

  typedef enum logic [2:0] {
    LEN_LO = 3'd0,
    LEN_HI = 3'd1,
    DATA   = 3'd2,
    CHK    = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } state_t;

  localparam logic [15:0] MAX_WORDS = 16'(instructions);

  state_t      state;
  state_t      state_nxt;
  logic        xfer;
  logic [1:0]  byte_cnt;
  logic [15:0] word_idx;
  logic [15:0] count;
  logic [15:0] count_full;
  logic [7:0]  csum;
  logic [23:0] word_buf;
  logic        last_word;

  // The loader only refuses bytes once the image is finished (either way).
  assign in_ready   = (state != DONE) && (state != ERR);
  assign xfer       = in_valid && in_ready;
  assign core_rst_n = (state == DONE);
  assign done       = (state == DONE);
  assign error      = (state == ERR);

  // Full word count as it will be once the high byte in flight is latched.
  assign count_full = {in_data, count[7:0]};
  assign last_word  = (word_idx == count - 16'd1);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= LEN_LO;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; every move except reload is gated by a byte transfer.
  always_comb begin
    state_nxt = state;
    case (state)
      LEN_LO: if (xfer) state_nxt = LEN_HI;
      LEN_HI: begin
        if (xfer) begin
          if (count_full == 16'd0)           state_nxt = CHK;
          else if (count_full > MAX_WORDS)   state_nxt = ERR;
          else                               state_nxt = DATA;
        end
      end
      DATA:   if (xfer && byte_cnt == 2'd3 && last_word) state_nxt = CHK;
      CHK: begin
        if (xfer) state_nxt = (in_data == csum) ? DONE : ERR;
      end
      DONE, ERR: if (start) state_nxt = LEN_LO;
      default: state_nxt = LEN_LO;
    endcase
  end

  // Datapath: length capture, word assembly, checksum and the one-cycle write strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_cnt   <= 2'd0;
      word_idx   <= 16'd0;
      count      <= 16'd0;
      csum       <= 8'd0;
      word_buf   <= 24'd0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
    end else begin
      imem_we <= 1'b0;
      if (!in_ready && start) begin
        byte_cnt <= 2'd0;
        word_idx <= 16'd0;
        count    <= 16'd0;
        csum     <= 8'd0;
        word_buf <= 24'd0;
      end else if (xfer) begin
        case (state)
          LEN_LO: count[7:0]  <= in_data;
          LEN_HI: count[15:8] <= in_data;
          DATA: begin
            csum     <= csum ^ in_data;
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0: word_buf[7:0]   <= in_data;
              2'd1: word_buf[15:8]  <= in_data;
              2'd2: word_buf[23:16] <= in_data;
              default: begin
                // Fourth byte completes the word: strobe it out next cycle.
                imem_we    <= 1'b1;
                imem_addr  <= word_idx[AW-1:0];
                imem_wdata <= {in_data, word_buf};
                word_idx   <= word_idx + 16'd1;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// tb/tb_boot_loader.sv - table-driven and randomized checks of boot_loader against a stream-level model
module tb_boot_loader;

  localparam int INSTR = 256;
  localparam int AW    = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'd0;
  logic          in_ready;
  logic          start = 1'b0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_rst_n;
  logic          done;
  logic          error;

  boot_loader #(.instructions(INSTR)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .start      (start),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst_n (core_rst_n),
    .done       (done),
    .error      (error)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int we_during_rst = 0;
  bit timeout_seen = 1'b0;
  bit poke_start = 1'b0;
  logic [39:0] got_w[$];
  logic [39:0] exp_w[$];

  typedef struct packed {
    logic [3:0]  len;
    logic [95:0] bytes;
    logic        exp_done;
    logic        exp_err;
    logic [3:0]  exp_nw;
  } vec_t;

  vec_t vt[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Record every write strobe seen by the instruction memory.
  always @(negedge clk) begin
    if (imem_we) begin
      got_w.push_back({imem_addr, imem_wdata});
      if (!rst) we_during_rst++;
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gaps);
    int n;
    in_valid = 1'b0;
    repeat (gaps) begin
      in_data = 8'($urandom);
      if (poke_start) start = 1'($urandom);
      @(posedge clk); #1;
    end
    start = 1'b0;
    in_data = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) timeout_seen = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data = 8'($urandom);
  endtask

  task automatic send_stream(input logic [7:0] s[$], input int max_gap);
    foreach (s[i]) send_byte(s[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
  endtask

  // Stream-level reference: decode the image from the byte list directly.
  task automatic model(input logic [7:0] s[$], output bit e_done, output bit e_err, output int used);
    int n;
    logic [7:0] x;
    logic [31:0] w;
    logic [AW-1:0] a;
    exp_w.delete();
    e_done = 1'b0;
    e_err  = 1'b0;
    n = int'({s[1], s[0]});
    x = 8'd0;
    if (n > INSTR) begin
      e_err = 1'b1;
      used  = 2;
      return;
    end
    for (int i = 0; i < n; i++) begin
      w = {s[5+4*i], s[4+4*i], s[3+4*i], s[2+4*i]};
      x = x ^ s[2+4*i] ^ s[3+4*i] ^ s[4+4*i] ^ s[5+4*i];
      a = AW'(i);
      exp_w.push_back({a, w});
    end
    used = 2 + 4*n + 1;
    if (s[2+4*n] == x) e_done = 1'b1;
    else               e_err  = 1'b1;
  endtask

  task automatic compare_writes(input string tag);
    check({tag, "_nwrites"}, got_w.size(), exp_w.size());
    for (int i = 0; i < got_w.size() && i < exp_w.size(); i++)
      check($sformatf("%s_write%0d", tag, i), got_w[i], exp_w[i]);
  endtask

  task automatic check_end(input string tag, input bit e_done, input bit e_err);
    check({tag, "_done"}, done, e_done);
    check({tag, "_error"}, error, e_err);
    check({tag, "_core_rst_n"}, core_rst_n, e_done);
    check({tag, "_in_ready"}, in_ready, 1'b0);
    check({tag, "_ready_timeout"}, timeout_seen, 1'b0);
    timeout_seen = 1'b0;
  endtask

  task automatic do_start(input string tag);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_start_done"}, done, 1'b0);
    check({tag, "_start_error"}, error, 1'b0);
    check({tag, "_start_ready"}, in_ready, 1'b1);
    check({tag, "_start_core_rst_n"}, core_rst_n, 1'b0);
  endtask

  // Two-word image; its checksum is the XOR of the eight data bytes (0x71).
  function automatic void load_ref(ref logic [7:0] s[$]);
    s = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00, 8'h71};
  endfunction

  task automatic mid_reset(input int ndata);
    logic [7:0] s[$];
    logic [7:0] p[$];
    bit ed, ee;
    int used;
    load_ref(s);
    for (int i = 0; i < 2 + ndata; i++) p.push_back(s[i]);
    send_stream(p, 0);
    #1 rst = 1'b0;
    #1;
    check($sformatf("midrst%0d_we", ndata), imem_we, 1'b0);
    check($sformatf("midrst%0d_addr", ndata), imem_addr, '0);
    check($sformatf("midrst%0d_wdata", ndata), imem_wdata, 32'd0);
    check($sformatf("midrst%0d_ready", ndata), in_ready, 1'b1);
    check($sformatf("midrst%0d_core", ndata), core_rst_n, 1'b0);
    got_w.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    send_stream(s, 0);
    model(s, ed, ee, used);
    compare_writes($sformatf("midrst%0d", ndata));
    check_end($sformatf("midrst%0d", ndata), ed, ee);
    do_start($sformatf("midrst%0d", ndata));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] s[$];
    vec_t v;
    bit ed, ee;
    int used;
    int n;
    int r;
    logic [7:0] x;

    vt[0] = {4'd11, 96'h0071_00A0_0113_0050_0093_0002, 1'b1, 1'b0, 4'd2};
    vt[1] = {4'd3,  96'h0000_0000_0000_0000_0000_0000, 1'b1, 1'b0, 4'd0};
    vt[2] = {4'd2,  96'h0000_0000_0000_0000_0000_0101, 1'b0, 1'b1, 4'd0};
    vt[3] = {4'd11, 96'h0038_00A0_0113_0050_0093_0002, 1'b0, 1'b1, 4'd2};
    vt[4] = {4'd3,  96'h0000_0000_0000_0000_0005_0000, 1'b0, 1'b1, 4'd0};
    vt[5] = {4'd7,  96'h0000_0000_0022_DEAD_BEEF_0001, 1'b1, 1'b0, 4'd1};
    vt[6] = {4'd2,  96'h0000_0000_0000_0000_0000_FFFF, 1'b0, 1'b1, 4'd0};

    // Held in reset with the source toggling: loader must stay quiet.
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = ~in_valid;
      in_data  = 8'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_core_rst_n", core_rst_n, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_addr", imem_addr, '0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_no_writes", we_during_rst, 0);
    rst = 1'b1;
    got_w.delete();

    // Directed vectors.
    for (int k = 0; k < 7; k++) begin
      v = vt[k];
      s.delete();
      got_w.delete();
      for (int i = 0; i < int'(v.len); i++) s.push_back(v.bytes[8*i +: 8]);
      send_stream(s, 0);
      check($sformatf("vec%0d_nwrites_tbl", k), got_w.size(), v.exp_nw);
      model(s, ed, ee, used);
      compare_writes($sformatf("vec%0d", k));
      check_end($sformatf("vec%0d", k), v.exp_done, v.exp_err);
      do_start($sformatf("vec%0d", k));
    end

    // Reference image with stalls and stray start pulses while loading.
    load_ref(s);
    got_w.delete();
    poke_start = 1'b1;
    send_stream(s, 3);
    poke_start = 1'b0;
    exp_w.delete();
    exp_w.push_back({8'd0, 32'h00500093});
    exp_w.push_back({8'd1, 32'h00A00113});
    compare_writes("stall");
    check_end("stall", 1'b1, 1'b0);
    do_start("stall");

    // Reset in mid-load: partial word dropped, pending strobe suppressed.
    mid_reset(6);
    mid_reset(8);

    // Randomized images against the model.
    for (int it = 0; it < 25; it++) begin
      r = (it == 0) ? 1 : int'($urandom_range(0, 9));
      case (r)
        0: n = 0;
        1: n = INSTR;
        2: n = INSTR + 1 + int'($urandom_range(0, 1000));
        default: n = int'($urandom_range(1, 8));
      endcase
      s.delete();
      s.push_back(8'(n));
      s.push_back(8'(n >> 8));
      if (n <= INSTR) begin
        x = 8'd0;
        for (int i = 0; i < 4*n; i++) begin
          s.push_back(8'($urandom));
          x = x ^ s[s.size()-1];
        end
        if ($urandom_range(0, 3) == 0) x = x ^ 8'($urandom_range(1, 255));
        s.push_back(x);
      end
      model(s, ed, ee, used);
      got_w.delete();
      send_stream(s, 2);
      compare_writes($sformatf("rnd%0d", it));
      check_end($sformatf("rnd%0d", it), ed, ee);
      do_start($sformatf("rnd%0d", it));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
